// File: rtl/fp_div_sequencer_pkg.sv
// Shared FP constants, sequencer state encodings and small helpers.
// Imported by the divider sequencer and the FP units around it.
package fp_div_sequencer_pkg;

    localparam logic [31:0] QNAN_SAMPLE_CONST = 32'h7FC0_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        FP_SEQ_IDLE = 2'd0,
        FP_SEQ_BUSY = 2'd1,
        FP_SEQ_DONE = 2'd2
    } fp_seq_state_e;

    function automatic logic is_dz(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (b == ZERO) && (a != ZERO);
    endfunction

endpackage

// File: rtl/FP_Dividor.sv
// Combinational single-precision divider, denormals flushed to zero.
// Quotient is rounded half-up on the first dropped bit.
module FP_Dividor
    import fp_div_sequencer_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    logic              sign;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [22:0]       fa;
    logic [22:0]       fb;
    logic              a_zero;
    logic              b_zero;
    logic              a_inf;
    logic              b_inf;
    logic              a_nan;
    logic              b_nan;
    logic [48:0]       num;
    logic [48:0]       den;
    logic [25:0]       q;
    logic [23:0]       mant;
    logic              guard;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] exp_q;
    logic signed [9:0] exp_r;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (&ea) && (fa == 23'd0);
    assign b_inf  = (&eb) && (fb == 23'd0);
    assign a_nan  = (&ea) && (fa != 23'd0);
    assign b_nan  = (&eb) && (fb != 23'd0);

    // Quotient of two 1.x mantissas lies in (0.5, 2): 26 bits suffice.
    assign num = {1'b1, fa, 25'd0};
    assign den = {25'd0, 1'b1, fb};
    assign q   = 26'(num / den);

    assign mant   = q[25] ? q[25:2] : q[24:1];
    assign guard  = q[25] ? q[1] : q[0];
    assign mant_r = {1'b0, mant} + {24'd0, guard};
    assign frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    assign exp_q  = $signed({2'b00, ea}) - $signed({2'b00, eb})
                  + (q[25] ? 10'sd127 : 10'sd126);
    assign exp_r  = exp_q + (mant_r[24] ? 10'sd1 : 10'sd0);

    always_comb begin
        result    = ZERO;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            result = QNAN_SAMPLE_CONST;
        end else if (a_inf || b_zero) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            result = {sign, 31'd0};
        end else if (exp_r > 10'sd254) begin
            result   = {sign, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else if (exp_r < 10'sd1) begin
            result    = {sign, 31'd0};
            underflow = 1'b1;
        end else begin
            result = {sign, exp_r[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_rr_arbiter2.sv
// Two-way round-robin grant; the side not granted last wins contention.
module fp_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/fp_div_sequencer.sv
// Shares one combinational FP_Dividor between COP1 and the microcode path,
// holding operands for a multicycle path and returning results via valid/ready.
module fp_div_sequencer
    import fp_div_sequencer_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    input  logic             flush,
    input  logic             clear_flags,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic             sticky_inv,
    output logic             sticky_dz,
    output logic             busy
);

    fp_seq_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             op_id;
    logic             last_grant;
    logic [1:0]       grant;
    logic [31:0]      div_result;
    logic             div_ovf;
    logic             div_unf;
    logic             accept;
    logic             acc_id;
    logic             capture;
    logic             new_inv;
    logic             new_dz;

    fp_rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Operand registers stay frozen while BUSY: this is the multicycle path.
    FP_Dividor u_div (
        .a         (op_a),
        .b         (op_b),
        .result    (div_result),
        .overflow  (div_ovf),
        .underflow (div_unf)
    );

    assign req_ready = (state == FP_SEQ_IDLE && !flush) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign acc_id    = req_ready[1];
    assign capture   = (state == FP_SEQ_BUSY) && (cnt == '0) && !flush;
    assign new_inv   = (div_result == QNAN_SAMPLE_CONST);
    assign new_dz    = is_dz(op_a, op_b);
    assign rsp_valid = (state == FP_SEQ_DONE) && !flush;
    assign busy      = (state != FP_SEQ_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FP_SEQ_IDLE;
            cnt           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_id         <= 1'b0;
            last_grant    <= 1'b1;
            rsp_id        <= 1'b0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
        end else if (flush) begin
            state <= FP_SEQ_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                FP_SEQ_IDLE: begin
                    if (accept) begin
                        op_a       <= req_a[acc_id];
                        op_b       <= req_b[acc_id];
                        op_id      <= acc_id;
                        last_grant <= acc_id;
                        cnt        <= CNT_W'(LATENCY - 1);
                        state      <= FP_SEQ_BUSY;
                    end
                end
                FP_SEQ_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_id        <= op_id;
                        rsp_result    <= div_result;
                        rsp_overflow  <= div_ovf;
                        rsp_underflow <= div_unf;
                        state         <= FP_SEQ_DONE;
                    end
                end
                FP_SEQ_DONE: begin
                    if (rsp_ready) begin
                        state <= FP_SEQ_IDLE;
                    end
                end
                default: state <= FP_SEQ_IDLE;
            endcase
        end
    end

    // A capture coinciding with clear_flags still records the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            sticky_inv <= 1'b0;
            sticky_dz  <= 1'b0;
        end else if (capture || clear_flags) begin
            sticky_ovf <= (sticky_ovf & ~clear_flags) | (capture & div_ovf);
            sticky_unf <= (sticky_unf & ~clear_flags) | (capture & div_unf);
            sticky_inv <= (sticky_inv & ~clear_flags) | (capture & new_inv);
            sticky_dz  <= (sticky_dz & ~clear_flags) | (capture & new_dz);
        end
    end

endmodule
